tcp_tx_arb: RTL
===============

// Module: tcp_tx_arb
// PURPOSE
//  Round-robin arbiter sharing one TCP transmit path (toward IPv4 tx) among N_SRC TCP connection engines.
//  Each source presents a tcp_ifc out_tx side. The arbiter grants one source, forwards its meta/strm
//  downstream, and routes the return handshake (req/acc/done) back to the granted source only.
//  Sits between the per-connection tcp tx engines and the single tcp->ipv4 tx formatter.
// PARAMETERS
//  N_SRC          4     number of requesting TCP engines, 2..16
//  TIMEOUT_TICKS  65535 watchdog limit in clk cycles (used only with TCP_TX_ARB_WDOG_EN)
// PORTS
//  clk     in   1                  system clock
//  rst     in   1                  synchronous reset, active-high
//  src     --   tcp_ifc.in_tx[N_SRC]   requesters: strm, meta, rdy in; req, acc, done out
//  dst     --   tcp_ifc.out_tx         shared path: strm, meta, rdy out; req, acc, done in
//  gnt_oh  out  N_SRC              one-hot current grant, 0 when idle (status)
//  busy    out  1                  high while any grant is held
//  wdog    out  1                  1-cycle pulse on watchdog release (0 if WDOG_EN absent)
// BEHAVIOUR
//  Reset: dst.strm='0, dst.meta='0, dst.rdy=0, src[*].req/acc/done=0, gnt_oh=0, busy=0, wdog=0, ptr=0.
//  FSM IDLE -> GRANT -> XFER -> GAP -> IDLE.
//  IDLE: scan src[*].rdy from ptr upward, modulo N_SRC. First hit is latched as gnt and the FSM goes to GRANT.
//   No hit: stay in IDLE.
//  GRANT: dst.rdy=1 and dst.meta=src[gnt].meta, both registered.
//   Appear 1 clk after the IDLE cycle that sampled rdy.
//   On dst.acc: pulse src[gnt].acc, go to XFER.
//   src[gnt].rdy dropping before acc: abort. Deassert dst.rdy next cycle, go to IDLE, ptr unchanged.
//  XFER: dst.strm = src[gnt].strm, registered, latency 1 clk.
//   dst.req is routed combinationally to src[gnt].req.
//   dst.rdy is held until dst.done.
//   On dst.done: pulse src[gnt].done, clear dst.rdy, go to GAP.
//  GAP: one idle cycle with dst.strm='0. Then ptr <= (gnt+1) mod N_SRC, go to IDLE.
//  Non-granted sources see req=acc=done=0 at all times.
//   Their strm and meta are ignored, and their rdy may stay high indefinitely.
//  Simultaneous rdy: the lowest index at or after ptr wins. Ptr wrap: index N_SRC-1 is followed by 0.
//  acc and done in the same cycle (zero-length payload): treat as acc then done, go straight to GAP.
//  Both pulses are forwarded in that cycle.
//  A new rdy from the just-served source during GAP is eligible only after the ptr advance.
//  Result: each source is served at most once per round while others wait.
//  rst mid-transfer: immediate return to IDLE with all outputs at reset values.
//   No done is reported to the source.
// CONFIGURATION
//  TCP_TX_ARB_WDOG_EN defined:
//   A counter clears on entering GRANT and counts every cycle in GRANT/XFER.
//   Reaching TIMEOUT_TICKS forces dst.rdy=0 and pulses wdog for 1 clk.
//   It also pulses src[gnt].done with dst.strm.err=1 on that cycle, then goes to GAP.
//  Not defined: no counter is built, wdog is tied to 0, and a grant is held until dst.done.
// STRUCTURE
//  tcp_vlg_pkg: add typedef enum {ARB_IDLE, ARB_GRANT, ARB_XFER, ARB_GAP} tcp_arb_fsm_t.
//  tcp_vlg_pkg: add localparam TCP_ARB_MAX_SRC = 16.
//  Sub-module rr_pick: combinational round-robin priority encoder.
//   Inputs: req vector, ptr. Outputs: one-hot grant, index, hit.
//   Reusable by other eth_vlg arbiters.
//  Interface arrays are unpacked into local vectors via a generate loop before muxing.
// TESTING
//  T1 single src: src[2].rdy=1 -> dst.rdy=1 one clk later with meta of src[2].
//     dst.acc -> src[2].acc pulses.
//     dst.done -> src[2].done pulses and gnt_oh returns to 0 after GAP.
//  T2 all 4 src rdy, ptr=0: grant order 0,1,2,3,0.
//     Each transfer is separated by exactly 1 GAP cycle, and no source sees another's acc/done.
//  T3 wrap: ptr=3, src[1] and src[3] rdy -> src[3] first, then src[1].
//  T4 abort: src[1].rdy drops in GRANT before acc -> dst.rdy=0 next clk, IDLE.
//     ptr stays 1, so src[1] is regranted when it reasserts.
//  T5 reset mid-XFER: rst for 1 clk during src[0] payload.
//     Next clk: dst.rdy=0, strm='0, gnt_oh=0, ptr=0, and no done to src[0].
//  T6 WDOG_EN, TIMEOUT_TICKS=100, dst.done withheld:
//     At cycle 100 after GRANT entry: wdog pulses, src[gnt].done pulses with err=1, next source granted.

Source files
------------

// File: rtl/tcp_tx_arb_pkg.sv
// Shared types for the TCP transmit arbiter: FSM states, stream/meta
// records and a small index-width helper.
package tcp_tx_arb_pkg;

  localparam int unsigned TCP_ARB_MAX_SRC = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_XFER,
    ARB_GAP
  } tcp_arb_fsm_t;

  // One payload byte plus framing flags.
  typedef struct packed {
    logic [7:0] dat;
    logic       vld;
    logic       sof;
    logic       eof;
    logic       err;
  } tcp_strm_t;

  // Per-packet header information handed to the IPv4 formatter.
  typedef struct packed {
    logic [31:0] ipv4_dst;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
  } tcp_meta_t;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Returns the first asserted request at or after ptr_i, wrapping from
// N-1 back to 0. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] idx_o,
  output logic          hit_o
);

  int unsigned pos;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    hit_o    = 1'b0;
    pos      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + N - 1 - k) % N;
      if (req_i[IW'(pos)]) begin
        hit_o               = 1'b1;
        idx_o               = IW'(pos);
        gnt_oh_o            = '0;
        gnt_oh_o[IW'(pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_arb.sv
// tcp_tx_arb: round-robin arbiter sharing one TCP transmit path among
// N_SRC connection engines. Forwards the granted source's meta/stream
// downstream and routes req/acc/done back to that source only.
// Optional watchdog release: define TCP_TX_ARB_WDOG_EN.
module tcp_tx_arb
  import tcp_tx_arb_pkg::*;
#(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned TIMEOUT_TICKS = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  // requesting engines
  input  tcp_strm_t            src_strm_i [N_SRC],
  input  tcp_meta_t            src_meta_i [N_SRC],
  input  logic [N_SRC-1:0]     src_rdy_i,
  output logic [N_SRC-1:0]     src_req_o,
  output logic [N_SRC-1:0]     src_acc_o,
  output logic [N_SRC-1:0]     src_done_o,
  // shared downstream path
  output tcp_strm_t            dst_strm_o,
  output tcp_meta_t            dst_meta_o,
  output logic                 dst_rdy_o,
  input  logic                 dst_req_i,
  input  logic                 dst_acc_i,
  input  logic                 dst_done_i,
  // status
  output logic [N_SRC-1:0]     gnt_oh_o,
  output logic                 busy_o,
  output logic                 wdog_o
);

  localparam int unsigned IW = arb_idx_w(N_SRC);

  tcp_arb_fsm_t     state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_SRC-1:0] gnt_oh_q, gnt_oh_d;
  logic             dst_rdy_q, dst_rdy_d;
  tcp_meta_t        dst_meta_q, dst_meta_d;
  tcp_strm_t        dst_strm_q, dst_strm_d;

  logic [N_SRC-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_hit;
  logic             wd_fire;

  tcp_strm_t        strm_v [N_SRC];
  tcp_meta_t        meta_v [N_SRC];
  tcp_strm_t        sel_strm;
  tcp_meta_t        sel_meta;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign strm_v[g] = src_strm_i[g];
    assign meta_v[g] = src_meta_i[g];
  end

  assign sel_strm = strm_v[gnt_q];
  assign sel_meta = meta_v[gnt_q];

  rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req_i    (src_rdy_i),
    .ptr_i    (ptr_q),
    .gnt_oh_o (pick_oh),
    .idx_o    (pick_idx),
    .hit_o    (pick_hit)
  );

`ifdef TCP_TX_ARB_WDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog counter: restarts on each grant, runs while a grant is active.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ARB_IDLE && pick_hit) begin
      wd_cnt_d = '0;
    end else if (state_q == ARB_GRANT || state_q == ARB_XFER) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end

  assign wd_fire = !rst && (state_q == ARB_GRANT || state_q == ARB_XFER) &&
                   (wd_cnt_q == CW'(TIMEOUT_TICKS));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_TICKS;
  assign wd_fire        = 1'b0;
`endif

  // Next-state logic; a pointer advance happens only on leaving GAP.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_oh_d   = gnt_oh_q;
    ptr_d      = ptr_q;
    dst_rdy_d  = dst_rdy_q;
    dst_meta_d = dst_meta_q;
    dst_strm_d = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_hit) begin
          state_d    = ARB_GRANT;
          gnt_d      = pick_idx;
          gnt_oh_d   = pick_oh;
          dst_rdy_d  = 1'b1;
          dst_meta_d = meta_v[pick_idx];
        end
      end
      ARB_GRANT: begin
        dst_meta_d = sel_meta;
        if (wd_fire) begin
          state_d   = ARB_GAP;
          dst_rdy_d = 1'b0;
        end else if (dst_acc_i) begin
          // acc+done together is a zero-length payload: skip XFER.
          if (dst_done_i) begin
            state_d   = ARB_GAP;
            dst_rdy_d = 1'b0;
          end else begin
            state_d = ARB_XFER;
          end
        end else if (!src_rdy_i[gnt_q]) begin
          state_d   = ARB_IDLE;
          dst_rdy_d = 1'b0;
          gnt_oh_d  = '0;
        end
      end
      ARB_XFER: begin
        if (wd_fire || dst_done_i) begin
          state_d   = ARB_GAP;
          dst_rdy_d = 1'b0;
        end else begin
          dst_strm_d = sel_strm;
        end
      end
      ARB_GAP: begin
        state_d  = ARB_IDLE;
        gnt_oh_d = '0;
        ptr_d    = (gnt_q == IW'(N_SRC - 1)) ? '0 : gnt_q + IW'(1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      ptr_q      <= '0;
      dst_rdy_q  <= 1'b0;
      dst_meta_q <= '0;
      dst_strm_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_oh_q   <= gnt_oh_d;
      ptr_q      <= ptr_d;
      dst_rdy_q  <= dst_rdy_d;
      dst_meta_q <= dst_meta_d;
      dst_strm_q <= dst_strm_d;
    end
  end

  // Return handshake routed to the granted source only; silenced during reset.
  always_comb begin
    src_req_o  = '0;
    src_acc_o  = '0;
    src_done_o = '0;
    if (!rst) begin
      if (state_q == ARB_GRANT) begin
        src_acc_o[gnt_q]  = dst_acc_i;
        src_done_o[gnt_q] = dst_acc_i & dst_done_i;
      end
      if (state_q == ARB_XFER) begin
        src_req_o[gnt_q]  = dst_req_i;
        src_done_o[gnt_q] = dst_done_i;
      end
      if (wd_fire) begin
        src_done_o[gnt_q] = 1'b1;
      end
    end
  end

  // Downstream outputs; a watchdog release overrides rdy and flags err.
  always_comb begin
    dst_rdy_o  = dst_rdy_q & ~wd_fire;
    dst_strm_o = dst_strm_q;
    if (wd_fire) begin
      dst_strm_o     = '0;
      dst_strm_o.err = 1'b1;
    end
  end

  assign dst_meta_o = dst_meta_q;
  assign gnt_oh_o   = gnt_oh_q;
  assign busy_o     = (state_q != ARB_IDLE);
  assign wdog_o     = wd_fire;

endmodule
